// File: rtl/fifo_rd_ctrl_if.sv
// Read-side port bundle of the async FIFO: request/address/status towards the consumer.
// FIFO_RD_LEVEL_EN adds the registered fill level rlevel.
interface fifo_rd_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic              rinc;
  logic [ADDR_W:0]   wgray_ptr;
  logic [ADDR_W-1:0] raddr;
  logic              rd_en;
  logic [ADDR_W:0]   rgray_ptr;
  logic              rempty;
  logic              ralmost_empty;
  logic              rvalid;
  logic              runderflow;
`ifdef FIFO_RD_LEVEL_EN
  logic [ADDR_W:0]   rlevel;
`endif

  modport slave (
    input  rinc, wgray_ptr,
    output raddr, rd_en, rgray_ptr, rempty, ralmost_empty, rvalid, runderflow
`ifdef FIFO_RD_LEVEL_EN
    , output rlevel
`endif
  );

  modport master (
    output rinc, wgray_ptr,
    input  raddr, rd_en, rgray_ptr, rempty, ralmost_empty, rvalid, runderflow
`ifdef FIFO_RD_LEVEL_EN
    , input rlevel
`endif
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: write-pointer synchroniser, read pointer,
// registered empty/almost-empty/valid/underflow. FIFO_RD_LEVEL_EN adds the rlevel output.
module fifo_rd_ctrl #(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input logic           rclk,
  input logic           rrst_n,
  fifo_rd_ctrl_if.slave rd
);
  localparam logic [ADDR_W:0] AE_LIM = AE_THRESH[ADDR_W:0];

  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] wq_sync;
  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] rbin_next;
  logic [ADDR_W:0] rgray_q;
  logic [ADDR_W:0] rgray_next;
  logic [ADDR_W:0] level_next;
  logic            rempty_q;
  logic            ralmost_empty_q;
  logic            rvalid_q;
  logic            runderflow_q;
  logic            rd_en;

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    for (int i = 0; i <= ADDR_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // Plain flop chain: no logic between stages so each bit resolves metastability cleanly.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rd.wgray_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wq_sync    = sync_q[SYNC_STAGES-1];
  assign wbin       = gray2bin(wq_sync);
  assign rd_en      = rd.rinc & ~rempty_q;
  assign rbin_next  = rbin + {{ADDR_W{1'b0}}, rd_en};
  assign rgray_next = rbin_next ^ (rbin_next >> 1);
  assign level_next = wbin - rbin_next;

  // Flags look at the post-increment pointer so the last-word read empties on the same edge.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin            <= '0;
      rgray_q         <= '0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      rvalid_q        <= 1'b0;
      runderflow_q    <= 1'b0;
    end else begin
      rbin            <= rbin_next;
      rgray_q         <= rgray_next;
      rempty_q        <= (rgray_next == wq_sync);
      ralmost_empty_q <= (level_next <= AE_LIM);
      rvalid_q        <= rd_en;
      runderflow_q    <= rd.rinc & rempty_q;
    end
  end

  assign rd.raddr         = rbin[ADDR_W-1:0];
  assign rd.rd_en         = rd_en;
  assign rd.rgray_ptr     = rgray_q;
  assign rd.rempty        = rempty_q;
  assign rd.ralmost_empty = ralmost_empty_q;
  assign rd.rvalid        = rvalid_q;
  assign rd.runderflow    = runderflow_q;

`ifdef FIFO_RD_LEVEL_EN
  logic [ADDR_W:0] rlevel_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel_q <= '0;
    end else begin
      rlevel_q <= level_next;
    end
  end

  assign rd.rlevel = rlevel_q;
`endif
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Parametrised read-side controller for the asynchronous FIFO; lives in the read clock domain (rclk).
- Synchronises the write-domain gray pointer internally and produces the memory read address and a registered empty flag.
- Adds almost-empty, read-data-valid and underflow reporting, plus an optional fill level.
- Pairs with the write-side controller and the dual-port FIFO memory (synchronous read, 1-cycle latency).

Parameters:
- ADDR_W, 3, memory address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
- SYNC_STAGES, 2, flop stages in the write-pointer synchroniser (legal >= 2).
- AE_THRESH, 1, almost-empty threshold in words (0 .. 2^ADDR_W).

Ports:
- rclk  in  1  read clock.
- rrst_n  in  1  asynchronous, active-low reset.
- rinc  in  1  read request.
- wgray_ptr  in  ADDR_W+1  write pointer, gray code, from write domain, unsynchronised.
- raddr  out  ADDR_W  memory read address.
- rd_en  out  1  memory read enable (combinational).
- rgray_ptr  out  ADDR_W+1  registered gray read pointer, to write domain.
- rempty  out  1  FIFO empty, registered.
- ralmost_empty  out  1  level <= AE_THRESH, registered.
- rvalid  out  1  memory read data valid.
- runderflow  out  1  one-cycle pulse: read attempted while empty.

Behaviour:
- Reset (asynchronous, all flops): rbin=0, rgray_ptr=0, synchroniser=0, rempty=1, ralmost_empty=1, rvalid=0, runderflow=0.
- Synchroniser: wgray_ptr passes through SYNC_STAGES flops on rclk; the last stage is wq_sync. No logic between stages.
- Accept: rd_en = rinc & ~rempty.
  - rbin_next = rbin + rd_en, modulo 2^(ADDR_W+1).
  - rgray_next = rbin_next ^ (rbin_next >> 1).
- Registers on each rclk edge: rbin <= rbin_next; rgray_ptr <= rgray_next.
- raddr = rbin[ADDR_W-1:0].
- Empty: rempty <= (rgray_next == wq_sync).
  - Empty is registered, so a read on the last word sets rempty on the same edge that advances the pointer. No extra read can slip through.
- Level: wbin = gray-to-binary(wq_sync); level_next = wbin - rbin_next, modulo 2^(ADDR_W+1), range 0..2^ADDR_W.
- Almost empty: ralmost_empty <= (level_next <= AE_THRESH).
- rvalid <= rd_en. Data is valid on the memory output during the cycle rvalid=1.
- runderflow <= rinc & rempty. Pointer, raddr and rgray_ptr are unchanged on an underflow; no memory read occurs.
- Wrap: the pointer rolls 2^(ADDR_W+1)-1 -> 0. The gray value changes exactly one bit per increment, including at the wrap. raddr wraps every 2^ADDR_W reads.
- Simultaneous events:
  - A write arriving (wq_sync changes) in the same cycle as the last-word read: rempty is evaluated against the new wq_sync, so it stays 0 if a word remains.
  - rinc with rempty=1 and a write just landing: the read is rejected (underflow pulse). Empty is pessimistic by design.
- Latency: a write becomes visible (rempty falls) SYNC_STAGES+1 rclk edges after wgray_ptr settles.
- Reset mid-operation: all state clears immediately; rempty=1 while rrst_n is low. An in-flight rvalid is dropped.

Optional Feature:
- Macro: FIFO_RD_LEVEL_EN.
- Defined: extra output rlevel (out, ADDR_W+1 bits), registered from level_next, reset 0.
- Undefined: no rlevel port. The level arithmetic is still built internally for ralmost_empty; behaviour is otherwise identical.

Test Plan:
- Reset with rinc=1 and wgray_ptr=4'b0101 (ADDR_W=3) -> rempty=1, raddr=0, rgray_ptr=0, rvalid=0, runderflow=0 throughout reset.
- wgray_ptr 0 -> 4'b0011 (2 words written), SYNC_STAGES=2 -> rempty falls on the 3rd rclk edge. ralmost_empty=0 with AE_THRESH=1. rlevel=2 if FIFO_RD_LEVEL_EN is defined.
- Continue from the previous scenario, then hold rinc=1 for 3 cycles:
  - edge 1: raddr=1, rgray_ptr=4'b0001, ralmost_empty=1.
  - edge 2: raddr=2, rgray_ptr=4'b0011, rempty=1.
  - rvalid is high for 2 cycles; runderflow pulses once after the 3rd request; raddr stays 2.
- Fill and drain 20 words with interleaved writes -> rbin crosses 15 -> 0, rgray_ptr goes 4'b1000 -> 4'b0000, raddr wraps 7 -> 0, no spurious rempty, no underflow.
- Mid-read reset (rrst_n low for 1 cycle while rinc=1 and level=4) -> all outputs return to their reset values asynchronously, rvalid goes 0 at once, and rempty=1 until the next sync latency elapses.
- wgray_ptr changes in the same cycle as the last-word read -> rempty stays 0 and the read completes with rvalid=1.
